player_input_ctrl: RTL and testbench
====================================

Name: player_input_ctrl

Overview:
Consumes the single-cycle debounced button pulses (left, right, up, down, fire) and turns them into game actions. It accumulates move requests and applies them once per frame to a clamped player X/Y tile position. Fire presses become a request/acknowledge handshake to the game logic, followed by a per-frame cooldown. It sits between the per-button debouncers and the VGA game-state/sprite logic.

Parameters:
XW, 7, width of x_pos
YW, 6, width of y_pos
X_MAX, 79, largest legal x_pos (inclusive)
Y_MAX, 59, largest legal y_pos (inclusive)
X_INIT, 40, x_pos after reset
Y_INIT, 50, y_pos after reset
STEP, 1, tiles moved per applied move (>=1)
COOLDOWN_FRAMES, 4, frame_ticks after fire_ack before next fire accepted (0 = none)

Ports:
sysclk  in  1  system clock
reset  in  1  synchronous, active-high reset
left_p  in  1  debounced single-cycle press pulse
right_p  in  1  debounced single-cycle press pulse
up_p  in  1  debounced single-cycle press pulse
down_p  in  1  debounced single-cycle press pulse
fire_p  in  1  debounced single-cycle press pulse
frame_tick  in  1  one-cycle pulse per frame (start of vblank)
fire_ack  in  1  game logic consumed fire request
x_pos  out  XW  player column
y_pos  out  YW  player row (0 = top)
moved  out  1  one-cycle pulse: position changed this frame
fire_req  out  1  fire request, held until acked
fire_x  out  XW  x_pos latched at fire acceptance
fire_y  out  YW  y_pos latched at fire acceptance
fire_drop  out  1  one-cycle pulse: fire_p ignored (busy)

Behaviour:
- One clock domain (sysclk). Reset is synchronous, active-high and wins over every other input. Reset values: x_pos=X_INIT, y_pos=Y_INIT, moved=0, fire_req=0, fire_x=0, fire_y=0, fire_drop=0, pending bits=0, FSM=IDLE, cooldown count=0.
- Pending bits pl/pr/pu/pd: each is set by its pulse and stays set until consumed. Repeated pulses within one frame collapse to one move.
- On frame_tick, apply the pending moves and clear all pending bits. A pulse in the same cycle as frame_tick is not applied; it sets its pending bit for the next frame.
- Opposing pending bits cancel: pl&pr gives no x move, pu&pd gives no y move. X and Y move independently, so diagonals are allowed.
- Arithmetic uses XW+1 / YW+1 bits, with no wrap:
  - right: x_pos >= X_MAX-STEP+1 gives X_MAX, else x_pos+STEP.
  - left: x_pos < STEP gives 0, else x_pos-STEP.
  - up decrements y and down increments y, with the same clamping against 0 and Y_MAX.
- New x_pos/y_pos are registered and visible the cycle after frame_tick, the same cycle moved pulses.
- moved=1 only if x or y actually changed. A move clamped at a wall gives moved=0.
- Fire FSM, states IDLE, REQ, COOL:
  - IDLE: fire_p takes the FSM to REQ. In the next cycle fire_req=1 and fire_x/fire_y hold the current x_pos/y_pos. The values captured are the registers as they stand in the fire_p cycle, before any same-cycle update.
  - REQ: fire_req stays high until fire_ack=1 is sampled. On that cycle fire_req drops next cycle and the FSM goes to COOL, or to IDLE if COOLDOWN_FRAMES=0. fire_ack outside REQ is ignored.
  - COOL: count frame_ticks. The FSM enters IDLE in the cycle after the COOLDOWN_FRAMES-th tick.
  - fire_p in REQ or COOL gives fire_drop=1 the next cycle, with no queueing.
  - fire_p in IDLE in the same cycle as frame_tick is accepted normally.
- Movement keeps working while fire is busy. fire_x/fire_y are stable while fire_req=1.
- Reset mid-request drops fire_req the cycle after reset and discards pending moves.

Decomposition:
- Shared package player_input_pkg: fire FSM state encodings (IDLE=2'd0, REQ=2'd1, COOL=2'd2) and the default X_MAX/Y_MAX/X_INIT/Y_INIT constants, so the renderer uses the same bounds.
- One sub-module, fire_ctrl. It contains the FSM, the cooldown counter, fire_req/fire_drop and the fire_x/fire_y latches, and takes x_pos/y_pos as inputs. Position and pending logic stay in the top module.

Test Plan:
- Reset, then right_p twice and up_p once, then frame_tick → next cycle x_pos=41, y_pos=49, moved=1. A second frame_tick with nothing pending → moved=0 and position unchanged.
- left_p and right_p in the same frame, then frame_tick → x_pos stays 40, moved=0. right_p in the same cycle as frame_tick → applied only at the following frame_tick (x=41).
- Clamp: drive 45 frames of right_p → x_pos saturates at 79 with no wrap to 0. The frame that hits the wall already at 79 gives moved=0. Repeat at y=0 with up_p and STEP=3: from y=2 the result is 0.
- Fire at (40,50) → fire_req=1 the next cycle with fire_x=40, fire_y=50. Hold fire_ack=0 for 10 cycles with moves applied → fire_x/fire_y unchanged. Then fire_ack → fire_req=0 the next cycle.
- After ack, fire_p during COOL → fire_drop pulse and no request. After 4 frame_ticks, fire_p → fire_req=1. With COOLDOWN_FRAMES=0, fire_p the cycle after ack is accepted.
- Reset asserted while fire_req=1 with pending moves → the next cycle shows fire_req=0 and x/y=X_INIT/Y_INIT, and the next frame_tick gives moved=0.

Source files
------------

// File: rtl/player_input_pkg.sv
// Shared constants for the player input path: fire FSM encodings and default
// playfield bounds, so the renderer clamps against the same limits.
package player_input_pkg;

  localparam int unsigned XW_DEF     = 7;
  localparam int unsigned YW_DEF     = 6;
  localparam int unsigned X_MAX_DEF  = 79;
  localparam int unsigned Y_MAX_DEF  = 59;
  localparam int unsigned X_INIT_DEF = 40;
  localparam int unsigned Y_INIT_DEF = 50;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    COOL = 2'd2
  } fire_state_e;

endpackage

// File: rtl/fire_ctrl.sv
// Fire request/acknowledge handshake with a frame-counted cooldown; captures
// the player position at the moment a fire press is accepted.
module fire_ctrl
  import player_input_pkg::*;
#(
  parameter int unsigned XW              = XW_DEF,
  parameter int unsigned YW              = YW_DEF,
  parameter int unsigned COOLDOWN_FRAMES = 4
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          fire_p,
  input  logic          frame_tick,
  input  logic          fire_ack,
  input  logic [XW-1:0] x_pos,
  input  logic [YW-1:0] y_pos,
  output logic          fire_req,
  output logic [XW-1:0] fire_x,
  output logic [YW-1:0] fire_y,
  output logic          fire_drop
);

  localparam int unsigned CW       = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam int unsigned CNT_LAST = (COOLDOWN_FRAMES == 0) ? 0 : COOLDOWN_FRAMES - 1;

  fire_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic          fire_req_q;
  logic          fire_drop_q;
  logic [XW-1:0] fire_x_q;
  logic [YW-1:0] fire_y_q;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fire_req_q  <= 1'b0;
      fire_drop_q <= 1'b0;
      fire_x_q    <= '0;
      fire_y_q    <= '0;
    end else begin
      fire_drop_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fire_p) begin
            state_q    <= REQ;
            fire_req_q <= 1'b1;
            fire_x_q   <= x_pos;
            fire_y_q   <= y_pos;
          end
        end
        REQ: begin
          fire_drop_q <= fire_p;
          if (fire_ack) begin
            fire_req_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= (COOLDOWN_FRAMES == 0) ? IDLE : COOL;
          end
        end
        COOL: begin
          fire_drop_q <= fire_p;
          // Leave on the last counted frame tick so IDLE is live the cycle after it.
          if (frame_tick) begin
            if (cnt_q == CW'(CNT_LAST)) begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fire_req  = fire_req_q;
  assign fire_drop = fire_drop_q;
  assign fire_x    = fire_x_q;
  assign fire_y    = fire_y_q;

endmodule

// File: rtl/player_input_ctrl.sv
// Turns debounced button pulses into per-frame clamped tile moves and a
// fire request handshake for the game logic.
module player_input_ctrl
  import player_input_pkg::*;
#(
  parameter int unsigned XW              = XW_DEF,
  parameter int unsigned YW              = YW_DEF,
  parameter int unsigned X_MAX           = X_MAX_DEF,
  parameter int unsigned Y_MAX           = Y_MAX_DEF,
  parameter int unsigned X_INIT          = X_INIT_DEF,
  parameter int unsigned Y_INIT          = Y_INIT_DEF,
  parameter int unsigned STEP            = 1,
  parameter int unsigned COOLDOWN_FRAMES = 4
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          left_p,
  input  logic          right_p,
  input  logic          up_p,
  input  logic          down_p,
  input  logic          fire_p,
  input  logic          frame_tick,
  input  logic          fire_ack,
  output logic [XW-1:0] x_pos,
  output logic [YW-1:0] y_pos,
  output logic          moved,
  output logic          fire_req,
  output logic [XW-1:0] fire_x,
  output logic [YW-1:0] fire_y,
  output logic          fire_drop
);

  localparam logic [XW:0] X_MAX_E  = (XW+1)'(X_MAX);
  localparam logic [XW:0] X_STEP_E = (XW+1)'(STEP);
  localparam logic [XW:0] X_RLIM   = (XW+1)'(X_MAX - STEP + 1);
  localparam logic [YW:0] Y_MAX_E  = (YW+1)'(Y_MAX);
  localparam logic [YW:0] Y_STEP_E = (YW+1)'(STEP);
  localparam logic [YW:0] Y_DLIM   = (YW+1)'(Y_MAX - STEP + 1);

  // Pending bits ordered {down, up, right, left}.
  logic [3:0]    pend_q, pend_d, pulses;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          moved_q, moved_d;
  logic [XW:0]   x_ext, x_nx;
  logic [YW:0]   y_ext, y_nx;

  assign pulses = {down_p, up_p, right_p, left_p};

  // Pulses coinciding with a frame tick are held over for the next frame.
  always_comb begin
    pend_d  = frame_tick ? pulses : (pend_q | pulses);
    x_ext   = {1'b0, x_q};
    y_ext   = {1'b0, y_q};
    x_nx    = x_ext;
    y_nx    = y_ext;
    x_d     = x_q;
    y_d     = y_q;
    moved_d = 1'b0;

    if (pend_q[1] && !pend_q[0]) begin
      x_nx = (x_ext >= X_RLIM) ? X_MAX_E : x_ext + X_STEP_E;
    end else if (pend_q[0] && !pend_q[1]) begin
      x_nx = (x_ext < X_STEP_E) ? '0 : x_ext - X_STEP_E;
    end

    if (pend_q[3] && !pend_q[2]) begin
      y_nx = (y_ext >= Y_DLIM) ? Y_MAX_E : y_ext + Y_STEP_E;
    end else if (pend_q[2] && !pend_q[3]) begin
      y_nx = (y_ext < Y_STEP_E) ? '0 : y_ext - Y_STEP_E;
    end

    if (frame_tick) begin
      x_d     = x_nx[XW-1:0];
      y_d     = y_nx[YW-1:0];
      moved_d = (x_d != x_q) || (y_d != y_q);
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      pend_q  <= '0;
      x_q     <= XW'(X_INIT);
      y_q     <= YW'(Y_INIT);
      moved_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      x_q     <= x_d;
      y_q     <= y_d;
      moved_q <= moved_d;
    end
  end

  assign x_pos = x_q;
  assign y_pos = y_q;
  assign moved = moved_q;

  fire_ctrl #(
    .XW              (XW),
    .YW              (YW),
    .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
  ) u_fire_ctrl (
    .sysclk     (sysclk),
    .reset      (reset),
    .fire_p     (fire_p),
    .frame_tick (frame_tick),
    .fire_ack   (fire_ack),
    .x_pos      (x_q),
    .y_pos      (y_q),
    .fire_req   (fire_req),
    .fire_x     (fire_x),
    .fire_y     (fire_y),
    .fire_drop  (fire_drop)
  );

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed bench for player_input_ctrl: default instance plus a STEP=3,
// no-cooldown instance sharing the same button inputs.
module tb_player_input_ctrl;

  localparam bit [6:0] L   = 7'd1;
  localparam bit [6:0] R   = 7'd2;
  localparam bit [6:0] U   = 7'd4;
  localparam bit [6:0] D   = 7'd8;
  localparam bit [6:0] F   = 7'd16;
  localparam bit [6:0] FT  = 7'd32;
  localparam bit [6:0] ACK = 7'd64;

  logic clk = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  logic left_p = 1'b0, right_p = 1'b0, up_p = 1'b0, down_p = 1'b0;
  logic fire_p = 1'b0, frame_tick = 1'b0, fire_ack = 1'b0;

  logic [6:0] a_x, b_x, a_fx, b_fx;
  logic [5:0] a_y, b_y, a_fy, b_fy;
  logic       a_moved, a_req, a_drop, b_moved, b_req, b_drop;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  player_input_ctrl dut_a (
    .sysclk(clk), .reset(reset_a),
    .left_p(left_p), .right_p(right_p), .up_p(up_p), .down_p(down_p),
    .fire_p(fire_p), .frame_tick(frame_tick), .fire_ack(fire_ack),
    .x_pos(a_x), .y_pos(a_y), .moved(a_moved),
    .fire_req(a_req), .fire_x(a_fx), .fire_y(a_fy), .fire_drop(a_drop)
  );

  player_input_ctrl #(.STEP(3), .COOLDOWN_FRAMES(0)) dut_b (
    .sysclk(clk), .reset(reset_b),
    .left_p(left_p), .right_p(right_p), .up_p(up_p), .down_p(down_p),
    .fire_p(fire_p), .frame_tick(frame_tick), .fire_ack(fire_ack),
    .x_pos(b_x), .y_pos(b_y), .moved(b_moved),
    .fire_req(b_req), .fire_x(b_fx), .fire_y(b_fy), .fire_drop(b_drop)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs; returns at the following negedge.
  task automatic drive(input bit [6:0] v);
    {fire_ack, frame_tick, fire_p, down_p, up_p, right_p, left_p} = v;
    @(negedge clk);
  endtask

  initial begin
    int ex;
    int nx;

    @(negedge clk);
    drive(0); drive(0);
    reset_a = 1'b0;
    drive(0);
    check("rst_x", a_x, 40);
    check("rst_y", a_y, 50);
    check("rst_moved", a_moved, 0);
    check("rst_req", a_req, 0);
    check("rst_fx", a_fx, 0);
    check("rst_fy", a_fy, 0);
    check("rst_drop", a_drop, 0);

    drive(R); drive(R); drive(U); drive(FT);
    check("diag_x", a_x, 41);
    check("diag_y", a_y, 49);
    check("diag_moved", a_moved, 1);
    drive(FT);
    check("idle_frame_moved", a_moved, 0);
    check("idle_frame_x", a_x, 41);

    drive(L | R); drive(FT);
    check("cancel_x", a_x, 41);
    check("cancel_moved", a_moved, 0);
    drive(R | FT);
    check("same_cyc_x", a_x, 41);
    check("same_cyc_moved", a_moved, 0);
    drive(FT);
    check("deferred_x", a_x, 42);
    check("deferred_moved", a_moved, 1);

    ex = 42;
    for (int i = 0; i < 45; i++) begin
      drive(R); drive(FT);
      nx = (ex < 79) ? ex + 1 : 79;
      check("clamp_x", a_x, nx);
      check("clamp_moved", a_moved, (nx != ex) ? 1 : 0);
      ex = nx;
    end
    check("clamp_final_x", a_x, 79);

    reset_a = 1'b1; drive(0); reset_a = 1'b0;
    drive(F);
    check("fire_req", a_req, 1);
    check("fire_x", a_fx, 40);
    check("fire_y", a_fy, 50);
    for (int i = 0; i < 5; i++) begin
      drive(R); drive(FT);
    end
    check("hold_x_pos", a_x, 45);
    check("hold_req", a_req, 1);
    check("hold_fx", a_fx, 40);
    check("hold_fy", a_fy, 50);
    drive(F);
    check("req_drop", a_drop, 1);
    check("req_drop_fx", a_fx, 40);
    drive(ACK);
    check("ack_req", a_req, 0);
    check("ack_drop_clear", a_drop, 0);

    drive(F);
    check("cool_drop", a_drop, 1);
    check("cool_no_req", a_req, 0);
    drive(FT); drive(FT); drive(FT);
    drive(F);
    check("cool3_drop", a_drop, 1);
    check("cool3_no_req", a_req, 0);
    drive(FT);
    drive(F);
    check("post_cool_req", a_req, 1);
    check("post_cool_fx", a_fx, 45);
    check("post_cool_drop", a_drop, 0);
    drive(ACK);
    check("ack2_req", a_req, 0);

    drive(FT); drive(FT); drive(FT); drive(FT);
    drive(F | FT);
    check("fire_on_tick_req", a_req, 1);
    drive(L); drive(U);
    reset_a = 1'b1;
    drive(0);
    reset_a = 1'b0;
    check("midreq_rst_req", a_req, 0);
    check("midreq_rst_x", a_x, 40);
    check("midreq_rst_y", a_y, 50);
    drive(FT);
    check("midreq_pend_moved", a_moved, 0);
    check("midreq_pend_x", a_x, 40);

    reset_a = 1'b1;
    drive(0);
    reset_b = 1'b0;
    check("b_rst_y", b_y, 50);
    for (int i = 0; i < 16; i++) begin
      drive(U); drive(FT);
    end
    check("b_y2", b_y, 2);
    drive(U); drive(FT);
    check("b_y0", b_y, 0);
    check("b_y0_moved", b_moved, 1);
    drive(U); drive(FT);
    check("b_wall_y", b_y, 0);
    check("b_wall_moved", b_moved, 0);
    check("b_x", b_x, 40);

    drive(F);
    check("b_req", b_req, 1);
    check("b_fy", b_fy, 0);
    drive(ACK);
    check("b_ack_req", b_req, 0);
    drive(F);
    check("b_nocool_req", b_req, 1);
    check("b_nocool_drop", b_drop, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
